muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 19 +
 rtl/muldiv_sequencer_div_step.sv | 26 ++
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants, ALU op codes and state encoding for the multi-cycle mul/div sequencer.
package muldiv_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_REMU = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One unsigned restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_step #(
  parameter int unsigned XLEN = muldiv_sequencer_pkg::XLEN
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_fits;

  // Partial remainder stays below the divisor, so the extra top bit gives a true sign.
  always_comb begin
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_diff  = w_shift - {2'b00, i_divisor};
    w_fits  = ~w_diff[XLEN+1];
    o_rem   = w_fits ? w_diff[XLEN:0] : w_shift[XLEN:0];
    o_quo   = {i_quo[XLEN-2:0], w_fits};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL / DIV / REMU unit that freezes the pipeline for 32 cycles per operation
// and presents the result for a single DONE cycle.
module muldiv_sequencer #(
  parameter int unsigned XLEN = muldiv_sequencer_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_alu_control,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  import muldiv_sequencer_pkg::*;

  muldiv_state_e    r_state;
  muldiv_state_e    w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_prod;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN:0]    r_rem;
  logic             r_is_rem;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_can_accept;
  logic             w_acc_mul;
  logic             w_acc_div;
  logic             w_acc_dz;
  logic             w_accept;
  logic             w_last;
  logic [XLEN-1:0]  w_prod_next;
  logic [XLEN:0]    w_rem_next;
  logic [XLEN-1:0]  w_quo_next;

  div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  // Next-state and accept decode; reset masks accepts so stall stays low.
  always_comb begin
    w_next       = r_state;
    w_can_accept = (r_state == IDLE) || (r_state == DONE);
    w_acc_mul    = 1'b0;
    w_acc_div    = 1'b0;
    w_acc_dz     = 1'b0;
    w_last       = (r_cnt == CNT_LAST);
    w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : '0);

    if (w_can_accept && i_start && !i_rst) begin
      w_acc_mul = (i_alu_control == ALU_MUL);
      w_acc_div = ((i_alu_control == ALU_DIV) || (i_alu_control == ALU_REMU)) && (i_op_b != '0);
      w_acc_dz  = ((i_alu_control == ALU_DIV) || (i_alu_control == ALU_REMU)) && (i_op_b == '0);
    end
    w_accept = w_acc_mul || w_acc_div || w_acc_dz;

    case (r_state)
      IDLE, DONE: begin
        if (w_acc_mul)      w_next = MUL_RUN;
        else if (w_acc_div) w_next = DIV_RUN;
        else if (w_acc_dz)  w_next = DONE;
        else                w_next = IDLE;
      end
      MUL_RUN: if (w_last) w_next = DONE;
      DIV_RUN: if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == MUL_RUN) || (w_next == DIV_RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Datapath: operand latch on accept, one iteration per run cycle, result on the last.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_is_rem  <= 1'b0;
      r_result  <= '0;
    end else if (w_acc_mul) begin
      r_mcand  <= i_op_a;
      r_mplier <= i_op_b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_acc_div) begin
      r_quo     <= i_op_a;
      r_divisor <= i_op_b;
      r_rem     <= '0;
      r_is_rem  <= (i_alu_control == ALU_REMU);
      r_cnt     <= '0;
    end else if (w_acc_dz) begin
      r_result <= (i_alu_control == ALU_REMU) ? i_op_a : '1;
    end else if (r_state == MUL_RUN) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) r_result <= w_prod_next;
      else        r_cnt    <= r_cnt + CNT_W'(1);
    end else if (r_state == DIV_RUN) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (w_last) r_result <= r_is_rem ? w_rem_next[XLEN-1:0] : w_quo_next;
      else        r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stall  = w_accept || r_busy;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule
